// File: rtl/alu_selftest_driver.sv
// Self-test initiator: replays a fixed vector list through the switch/button
// load protocol of the ALU input block and scores the LED results.
module alu_selftest_driver #(
    parameter int NB_DATA       = 6,
    parameter int NB_BTN        = 3,
    parameter int HOLD_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int N_VECTORS     = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_leds,
    output logic [NB_DATA-1:0] o_switches,
    output logic [NB_BTN-1:0]  o_buttons,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [3:0]         o_fail_count,
    output logic [2:0]         o_fail_index
);

    localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]        LAST_IDX    = 3'(N_VECTORS - 1);
    localparam logic [NB_BTN-1:0] BTN_A       = NB_BTN'(3'b100);
    localparam logic [NB_BTN-1:0] BTN_B       = NB_BTN'(3'b010);
    localparam logic [NB_BTN-1:0] BTN_OP      = NB_BTN'(3'b001);

    typedef enum logic [3:0] {
        IDLE, LOAD_A, GAP_A, LOAD_B, GAP_B, LOAD_OP, GAP_OP, SETTLE, CHECK, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         acc_cnt_q, acc_cnt_d;
    logic [2:0]         acc_idx_q, acc_idx_d;
    logic [NB_DATA-1:0] switches_q, switches_d;
    logic [NB_BTN-1:0]  buttons_q, buttons_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [3:0]         fail_count_q, fail_count_d;
    logic [2:0]         fail_index_q, fail_index_d;
    logic [4*NB_DATA-1:0] vec;
    logic [NB_DATA-1:0] vec_a, vec_b, vec_op, vec_exp;

    function automatic logic [4*NB_DATA-1:0] rom(input logic [2:0] idx);
        case (idx)
            3'd0:    rom = {NB_DATA'(15), NB_DATA'(20), NB_DATA'(6'b100000), NB_DATA'(35)};
            3'd1:    rom = {NB_DATA'(20), NB_DATA'(15), NB_DATA'(6'b100010), NB_DATA'(5)};
            3'd2:    rom = {NB_DATA'(15), NB_DATA'(20), NB_DATA'(6'b100100), NB_DATA'(4)};
            3'd3:    rom = {NB_DATA'(20), NB_DATA'(15), NB_DATA'(6'b100101), NB_DATA'(31)};
            3'd4:    rom = {NB_DATA'(15), NB_DATA'(20), NB_DATA'(6'b100110), NB_DATA'(27)};
            default: rom = {NB_DATA'(20), NB_DATA'(15), NB_DATA'(6'b100111), NB_DATA'(32)};
        endcase
    endfunction

    always_comb begin
        vec     = rom(idx_q);
        vec_a   = vec[4*NB_DATA-1 -: NB_DATA];
        vec_b   = vec[3*NB_DATA-1 -: NB_DATA];
        vec_op  = vec[2*NB_DATA-1 -: NB_DATA];
        vec_exp = vec[NB_DATA-1:0];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        acc_cnt_d = acc_cnt_q;
        acc_idx_d = acc_idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d   = LOAD_A;
                    idx_d     = '0;
                    cnt_d     = '0;
                    acc_cnt_d = '0;
                    acc_idx_d = '0;
                end
            end
            LOAD_A, LOAD_B, LOAD_OP: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    case (state_q)
                        LOAD_A:  state_d = GAP_A;
                        LOAD_B:  state_d = GAP_B;
                        default: state_d = GAP_OP;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP_A:  state_d = LOAD_B;
            GAP_B:  state_d = LOAD_OP;
            GAP_OP: state_d = SETTLE;
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (i_leds != vec_exp) begin
                    if (acc_cnt_q != '1) acc_cnt_d = acc_cnt_q + 4'd1;
                    if (acc_cnt_q == '0) acc_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = LOAD_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are a registered image of the current state, so every port lags
    // the state register by one cycle and changes together on the same edge.
    always_comb begin
        switches_d   = switches_q;
        buttons_d    = '0;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        pass_d       = 1'b0;
        fail_count_d = acc_cnt_q;
        fail_index_d = acc_idx_q;
        case (state_q)
            IDLE: begin
                switches_d = '0;
                busy_d     = 1'b0;
            end
            LOAD_A: begin
                switches_d = vec_a;
                buttons_d  = BTN_A;
            end
            LOAD_B: begin
                switches_d = vec_b;
                buttons_d  = BTN_B;
            end
            LOAD_OP: begin
                switches_d = vec_op;
                buttons_d  = BTN_OP;
            end
            DONE: begin
                switches_d = '0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                pass_d     = (acc_cnt_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            acc_cnt_q    <= '0;
            acc_idx_q    <= '0;
            switches_q   <= '0;
            buttons_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= '0;
            fail_index_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_idx_q    <= acc_idx_d;
            switches_q   <= switches_d;
            buttons_q    <= buttons_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            fail_index_q <= fail_index_d;
        end
    end

    assign o_switches   = switches_q;
    assign o_buttons    = buttons_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_pass       = pass_q;
    assign o_fail_count = fail_count_q;
    assign o_fail_index = fail_index_q;

endmodule

// File: doc/alu_selftest_driver.md
Name: alu_selftest_driver

Overview:
- Built-in self-test initiator for the switch/button operand-load interface of the ALU input block.
- Plays a fixed vector list by driving the same switches/buttons protocol a user drives by hand: load A, load B, load Op. After each vector it samples the 6-bit LED result and compares it with the expected value.
- Sits between the top level and the ALU input block. It is muxed in place of the board switches/buttons when self-test is selected, and reports pass/fail.

Parameters:
- NB_DATA, 6, width of switches, operands, opcode and LED result
- NB_BTN, 3, button bus width (bit2 = load A, bit1 = load B, bit0 = load Op)
- HOLD_CYCLES, 2, cycles a button is held high per load (must be >= 1)
- SETTLE_CYCLES, 2, cycles waited after Op load before sampling LEDs (must be >= 1)
- N_VECTORS, 6, number of vectors in the internal ROM

Ports:
- clock  input  1  system clock, all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- i_start  input  1  one-cycle pulse that starts a run; honoured only in IDLE or DONE
- i_leds  input  NB_DATA  result from the ALU input block
- o_switches  output  NB_DATA  operand/opcode value driven to the ALU input block
- o_buttons  output  NB_BTN  load strobes, one-hot or zero
- o_busy  output  1  high from the first LOAD_A cycle until DONE is entered
- o_done  output  1  sticky high in DONE until the next accepted i_start or reset
- o_pass  output  1  valid while o_done; 1 when o_fail_count == 0
- o_fail_count  output  4  number of mismatching vectors, saturates at 15
- o_fail_index  output  3  index of the first failing vector; 0 if none failed

Behaviour:
- Reset:
  - Takes effect on the clock edge, including mid-run.
  - Next state is IDLE.
  - o_switches=0, o_buttons=0, o_busy=0, o_done=0, o_pass=0, o_fail_count=0, o_fail_index=0.
  - Vector index and cycle counter cleared.
- All outputs are registered.
- ROM vectors, in order {A, B, Op, expected}:
  - 0: {15, 20, 6'b100000 ADD, 35}
  - 1: {20, 15, 6'b100010 SUB, 5}
  - 2: {15, 20, 6'b100100 AND, 4}
  - 3: {20, 15, 6'b100101 OR, 31}
  - 4: {15, 20, 6'b100110 XOR, 27}
  - 5: {20, 15, 6'b100111 NOR, 32}
- States: IDLE, LOAD_A, GAP_A, LOAD_B, GAP_B, LOAD_OP, GAP_OP, SETTLE, CHECK, DONE.
- IDLE / DONE + i_start:
  - Go to LOAD_A.
  - Clear vector index, fail_count, fail_index, o_done, o_pass.
  - Set o_busy.
- LOAD_x (HOLD_CYCLES cycles):
  - o_switches = field x of the current vector.
  - o_buttons = the matching single bit (100 for A, 010 for B, 001 for Op).
- GAP_x (1 cycle): o_buttons=000, o_switches held unchanged. This gives a clean falling edge so data never changes while a strobe is high.
- Transitions: GAP_A -> LOAD_B; GAP_B -> LOAD_OP; GAP_OP -> SETTLE.
- SETTLE: o_buttons=000; lasts SETTLE_CYCLES cycles, then CHECK.
- CHECK (1 cycle):
  - Compare i_leds with expected.
  - On mismatch: increment fail_count (saturating at 15). If this is the first failure, load fail_index with the vector index.
  - If the index is N_VECTORS-1, go to DONE. Otherwise increment the index and go to LOAD_A.
- DONE: o_busy=0, o_done=1, o_pass=(fail_count==0). o_switches=0, o_buttons=0.
- Cycles per vector = 3*(HOLD_CYCLES+1) + SETTLE_CYCLES + 1 = 12 at defaults. Full run = 72 cycles. o_done rises 73 edges after the i_start edge.
- i_start while busy is ignored, with no restart and no counter change.
- Invariant: o_buttons has at most one bit set at all times.
- o_switches changes only on cycles where o_buttons is 000 on the previous cycle, or on the first LOAD cycle, where the new data and the strobe rise together.

Test Plan:
- Golden ALU model on i_leds, pulse i_start -> exact button/switch sequence per ROM (e.g. cycles 1-2: switches=15, buttons=100); o_done rises at edge 73; o_pass=1; fail_count=0.
- ALU model with SUB returning 0 -> o_done, o_pass=0, o_fail_count=1, o_fail_index=1.
- Model returning 0 for every op -> o_fail_count=6, o_fail_index=0, o_pass=0.
- i_start pulsed again at cycle 30 of a run -> ignored; completion timing is unchanged and equals the single-start run.
- reset asserted during LOAD_B of vector 2 -> next edge: all outputs 0, state IDLE. A new i_start then runs a full clean 72-cycle pass.
- After DONE with failures, pulse i_start with a golden model -> counters cleared, o_done low during the run, final o_pass=1. Assertion throughout: o_buttons is never multi-hot, and switches are stable while any button is high.
